// File: rtl/fft_out_serializer.sv
// fft_out_serializer
//   Ping-pong frame buffer behind the four-lane FFT output commutator.
//   A frame of N samples arrives as N/4 consecutive four-sample beats and is
//   captured into one of two banks. Completed frames drain one sample per
//   cycle, in natural index order, over a valid/ready stream with frame markers.
//
// Parameters
//   NB  sample width in bits
//   N   FFT length in samples (power of two, >= 8)
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   start       pulse marking beat 0 of a frame on input_data
//   input_data  beat k: [NB*4-1:NB*3]=4k, [NB*3-1:NB*2]=4k+1, [NB*2-1:NB]=4k+2, [NB-1:0]=4k+3
//   out_data    registered output sample
//   out_valid   out_data is valid
//   out_ready   sink accepts when out_valid && out_ready
//   out_sof     high with sample index 0
//   out_eof     high with sample index N-1
//   out_index   index of out_data
//   overflow    sticky; a frame was dropped because its target bank was full
//   busy        a bank is full or being filled
module fft_out_serializer #(
  parameter int NB = 16,
  parameter int N  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NB*4-1:0]      input_data,
  output logic [NB-1:0]        out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic [$clog2(N)-1:0] out_index,
  output logic                 overflow,
  output logic                 busy
);

  localparam int AW    = $clog2(N);
  localparam int BEATS = N / 4;
  localparam int BW    = $clog2(BEATS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic { W_IDLE, W_FILL   } w_state_t;
  typedef enum logic { R_IDLE, R_STREAM } r_state_t;

  // Both banks in one array, addressed as {bank, sample_index}.
  logic [NB-1:0] mem [0:2*N-1];

  w_state_t      w_state, w_next;
  r_state_t      r_state, r_next;
  logic [BW-1:0] beat_cnt, beat_next;
  logic          wr_bank, wr_bank_next;
  logic          rd_bank, rd_bank_next;
  logic [AW-1:0] rd_addr, rd_addr_next;
  logic [1:0]    full;
  logic [1:0]    set_full, clr_full;

  logic          we;
  logic [BW-1:0] wr_beat;
  logic          ovf_set;

  logic          ld;
  logic          ld_bank;
  logic [AW-1:0] ld_addr;
  logic          valid_next, sof_next, eof_next;

  // ---------------------------------------------------------------------------
  // Write side: W_IDLE waits for start, W_FILL captures one beat per cycle.
  // A bank being freed by the reader this cycle counts as free, so a start
  // that collides with the release is accepted.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next       = w_state;
    beat_next    = beat_cnt;
    wr_bank_next = wr_bank;
    we           = 1'b0;
    wr_beat      = '0;
    set_full     = '0;
    ovf_set      = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (start) begin
          if (!full[wr_bank] || clr_full[wr_bank]) begin
            we        = 1'b1;
            wr_beat   = '0;
            beat_next = BW'(1);
            w_next    = W_FILL;
          end else begin
            ovf_set = 1'b1;
          end
        end
      end
      W_FILL: begin
        we = 1'b1;
        if (start) begin
          // Restart: the partial frame is simply overwritten from beat 0.
          wr_beat   = '0;
          beat_next = BW'(1);
        end else begin
          wr_beat = beat_cnt;
          if (beat_cnt == LAST_BEAT) begin
            set_full[wr_bank] = 1'b1;
            wr_bank_next      = ~wr_bank;
            beat_next         = '0;
            w_next            = W_IDLE;
          end else begin
            beat_next = beat_cnt + BW'(1);
          end
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read side: rd_addr is the index currently held in the output register.
  // The output register reloads either when empty or on a handshake, so a
  // stalled sample stays put. The bank is released only when its last sample
  // is accepted; if the other bank is already full its sample 0 is loaded in
  // the same cycle, giving a bubble-free frame boundary.
  // ---------------------------------------------------------------------------
  always_comb begin
    r_next       = r_state;
    rd_bank_next = rd_bank;
    rd_addr_next = rd_addr;
    valid_next   = out_valid;
    sof_next     = out_sof;
    eof_next     = out_eof;
    ld           = 1'b0;
    ld_bank      = rd_bank;
    ld_addr      = rd_addr;
    clr_full     = '0;
    case (r_state)
      R_IDLE: begin
        if (full[rd_bank]) begin
          r_next       = R_STREAM;
          rd_addr_next = '0;
        end
      end
      R_STREAM: begin
        if (!out_valid) begin
          ld = 1'b1;
        end else if (out_ready) begin
          if (rd_addr == LAST_ADDR) begin
            clr_full[rd_bank] = 1'b1;
            rd_bank_next      = ~rd_bank;
            rd_addr_next      = '0;
            if (full[~rd_bank]) begin
              ld      = 1'b1;
              ld_bank = ~rd_bank;
              ld_addr = '0;
            end else begin
              r_next     = R_IDLE;
              valid_next = 1'b0;
              sof_next   = 1'b0;
              eof_next   = 1'b0;
            end
          end else begin
            ld           = 1'b1;
            ld_addr      = rd_addr + AW'(1);
            rd_addr_next = rd_addr + AW'(1);
          end
        end
      end
      default: r_next = R_IDLE;
    endcase
    if (ld) begin
      valid_next = 1'b1;
      sof_next   = (ld_addr == '0);
      eof_next   = (ld_addr == LAST_ADDR);
    end
  end

  // ---------------------------------------------------------------------------
  // State and control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state   <= W_IDLE;
      r_state   <= R_IDLE;
      beat_cnt  <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      rd_addr   <= '0;
      full      <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_data  <= '0;
    end else begin
      w_state   <= w_next;
      r_state   <= r_next;
      beat_cnt  <= beat_next;
      wr_bank   <= wr_bank_next;
      rd_bank   <= rd_bank_next;
      rd_addr   <= rd_addr_next;
      full      <= (full & ~clr_full) | set_full;
      overflow  <= overflow | ovf_set;
      out_valid <= valid_next;
      out_sof   <= sof_next;
      out_eof   <= eof_next;
      if (ld) begin
        out_data <= mem[{ld_bank, ld_addr}];
      end
    end
  end

  // Frame storage: four lanes written per beat, no reset needed since the
  // full flags gate every read.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned j = 0; j < 4; j++) begin
        mem[{wr_bank, wr_beat, 2'(j)}] <= input_data[NB*(3-j) +: NB];
      end
    end
  end

  assign out_index = rd_addr;
  assign busy      = full[0] | full[1] | (w_state == W_FILL);

endmodule

// File: tb/tb_fft_out_serializer.sv
// tb_fft_out_serializer
//   Self-checking bench for fft_out_serializer (NB=16, N=64). Frames are
//   driven beat by beat; each complete frame pushes its expected samples into
//   a scoreboard queue that is popped as the DUT hands samples over.
module tb_fft_out_serializer;

  localparam int NB    = 16;
  localparam int N     = 64;
  localparam int AW    = $clog2(N);
  localparam int BEATS = N / 4;

  logic              clk;
  logic              reset;
  logic              start;
  logic [NB*4-1:0]   input_data;
  logic [NB-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sof;
  logic              out_eof;
  logic [AW-1:0]     out_index;
  logic              overflow;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  logic [NB-1:0] exp_data [$];
  int            exp_idx  [$];

  fft_out_serializer #(.NB(NB), .N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .input_data (input_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .out_index  (out_index),
    .overflow   (overflow),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NB-1:0] samp(input int fid, input int idx);
    return NB'(fid * 256 + idx);
  endfunction

  // Drives nbeats beats of frame fid starting at the next edge. Called and
  // returns at 1 time unit after a rising edge. When keep is set the whole
  // frame is queued as expected output once its last beat is driven.
  task automatic send_frame(input int fid, input int nbeats, input bit keep);
    for (int k = 0; k < nbeats; k++) begin
      start = (k == 0);
      for (int j = 0; j < 4; j++) input_data[NB*(3-j) +: NB] = samp(fid, 4*k + j);
      if (keep && k == nbeats - 1) begin
        for (int i = 0; i < N; i++) begin
          exp_data.push_back(samp(fid, i));
          exp_idx.push_back(i);
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; input_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_data !== '0 || out_valid !== 1'b0 || out_sof !== 1'b0 || out_eof !== 1'b0 ||
        out_index !== '0 || overflow !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: data=%h valid=%b sof=%b eof=%b idx=%0d ovf=%b busy=%b required all zero",
               out_data, out_valid, out_sof, out_eof, out_index, overflow, busy);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int got = 0, cyc = 0, first = -1;
    logic [NB-1:0] d; int i;
    bit seen_busy = 0;
    out_ready = 1'b1;
    fork
      send_frame(0, BEATS, 1'b1);
      begin
        while (got < N && cyc < 400) begin
          if (busy) seen_busy = 1;
          if (out_valid) begin
            if (first < 0) first = cyc;
            checks++;
            if (exp_data.size() == 0) begin
              failures++; $display("FAIL single_unexpected: idx=%0d data=%h with empty scoreboard", out_index, out_data);
            end else begin
              d = exp_data.pop_front(); i = exp_idx.pop_front();
              if (out_data !== d || out_index !== AW'(i) || out_sof !== (i == 0) || out_eof !== (i == N-1)) begin
                failures++;
                $display("FAIL single_sample: data=%h idx=%0d sof=%b eof=%b required data=%h idx=%0d sof=%b eof=%b",
                         out_data, out_index, out_sof, out_eof, d, i, i == 0, i == N-1);
              end
            end
            got++;
          end
          @(posedge clk); #1; cyc++;
        end
      end
    join
    checks++;
    if (got != N) begin failures++; $display("FAIL single_timeout: got %0d samples required %0d", got, N); end
    checks++;
    if (first != BEATS + 2) begin failures++; $display("FAIL single_latency: first valid at %0d required %0d", first, BEATS + 2); end
    checks++;
    if (cyc - first != N) begin failures++; $display("FAIL single_contiguous: frame took %0d cycles required %0d", cyc - first, N); end
    checks++;
    if (!seen_busy) begin failures++; $display("FAIL single_busy: busy never seen high required high during frame"); end
    checks++;
    if (overflow !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL single_after: ovf=%b valid=%b busy=%b required 0 0 0", overflow, out_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    int got = 0, cyc = 0, bubbles = 0;
    logic [NB-1:0] d; int i;
    out_ready = 1'b1;
    fork
      for (int f = 1; f <= 3; f++) begin
        send_frame(f, BEATS, 1'b1);
        repeat (N - BEATS) begin @(posedge clk); #1; end
      end
      begin
        while (got < 3*N && cyc < 1000) begin
          if (out_valid) begin
            checks++;
            if (exp_data.size() == 0) begin
              failures++; $display("FAIL b2b_unexpected: idx=%0d data=%h with empty scoreboard", out_index, out_data);
            end else begin
              d = exp_data.pop_front(); i = exp_idx.pop_front();
              if (out_data !== d || out_index !== AW'(i) || out_sof !== (i == 0) || out_eof !== (i == N-1)) begin
                failures++;
                $display("FAIL b2b_sample: data=%h idx=%0d sof=%b eof=%b required data=%h idx=%0d",
                         out_data, out_index, out_sof, out_eof, d, i);
              end
            end
            got++;
          end else if (got > 0) begin
            bubbles++;
          end
          @(posedge clk); #1; cyc++;
        end
      end
    join
    checks++;
    if (got != 3*N) begin failures++; $display("FAIL b2b_timeout: got %0d samples required %0d", got, 3*N); end
    checks++;
    if (bubbles != 0) begin failures++; $display("FAIL b2b_bubbles: %0d idle cycles required 0", bubbles); end
  endtask

  task automatic test_random_ready();
    int got = 0, cyc = 0;
    logic [NB-1:0] d; int i;
    bit stalled = 0;
    logic [NB-1:0] hold_d; logic [AW-1:0] hold_i;
    fork
      begin
        send_frame(4, BEATS, 1'b1);
        repeat (N - BEATS) begin @(posedge clk); #1; end
        send_frame(5, BEATS, 1'b1);
      end
      begin
        while (got < 2*N && cyc < 3000) begin
          if (stalled) begin
            checks++;
            if (out_data !== hold_d || out_index !== hold_i || out_valid !== 1'b1) begin
              failures++;
              $display("FAIL stall_hold: data=%h idx=%0d valid=%b required data=%h idx=%0d valid=1",
                       out_data, out_index, out_valid, hold_d, hold_i);
            end
          end
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            checks++;
            if (exp_data.size() == 0) begin
              failures++; $display("FAIL random_unexpected: idx=%0d data=%h with empty scoreboard", out_index, out_data);
            end else begin
              d = exp_data.pop_front(); i = exp_idx.pop_front();
              if (out_data !== d || out_index !== AW'(i) || out_sof !== (i == 0) || out_eof !== (i == N-1)) begin
                failures++;
                $display("FAIL random_sample: data=%h idx=%0d sof=%b eof=%b required data=%h idx=%0d",
                         out_data, out_index, out_sof, out_eof, d, i);
              end
            end
            got++;
          end
          stalled = out_valid && !out_ready;
          hold_d  = out_data;
          hold_i  = out_index;
          @(posedge clk); #1; cyc++;
        end
      end
    join
    out_ready = 1'b1;
    checks++;
    if (got != 2*N) begin failures++; $display("FAIL random_timeout: got %0d samples required %0d", got, 2*N); end
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL random_overflow: ovf=%b required 0", overflow); end
  endtask

  task automatic test_restart();
    int got = 0, cyc = 0;
    logic [NB-1:0] d; int i;
    out_ready = 1'b1;
    fork
      begin
        send_frame(7, 5, 1'b0);
        send_frame(8, BEATS, 1'b1);
      end
      begin
        while (got < N && cyc < 400) begin
          if (out_valid) begin
            checks++;
            if (exp_data.size() == 0) begin
              failures++; $display("FAIL restart_unexpected: idx=%0d data=%h with empty scoreboard", out_index, out_data);
            end else begin
              d = exp_data.pop_front(); i = exp_idx.pop_front();
              if (out_data !== d || out_index !== AW'(i)) begin
                failures++;
                $display("FAIL restart_sample: data=%h idx=%0d required data=%h idx=%0d", out_data, out_index, d, i);
              end
            end
            got++;
          end
          @(posedge clk); #1; cyc++;
        end
      end
    join
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (got != N || out_valid !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("FAIL restart_frame_count: got %0d valid=%b ovf=%b required %0d 0 0", got, out_valid, overflow, N);
    end
  endtask

  task automatic test_overflow();
    int got = 0, cyc = 0;
    logic [NB-1:0] d; int i;
    out_ready = 1'b0;
    send_frame(1, BEATS, 1'b1);
    send_frame(2, BEATS, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early: ovf=%b required 0", overflow); end
    send_frame(3, BEATS, 1'b0);
    checks++;
    if (overflow !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL ovf_set: ovf=%b busy=%b required 1 1", overflow, busy);
    end
    repeat (20) begin @(posedge clk); #1; end
    checks++;
    if (overflow !== 1'b1 || out_valid !== 1'b1 || out_index !== '0 || out_data !== samp(1, 0) || out_sof !== 1'b1) begin
      failures++;
      $display("FAIL ovf_hold: ovf=%b valid=%b idx=%0d data=%h sof=%b required 1 1 0 %h 1",
               overflow, out_valid, out_index, out_data, out_sof, samp(1, 0));
    end
    out_ready = 1'b1;
    while (got < 2*N && cyc < 600) begin
      if (out_valid) begin
        checks++;
        if (exp_data.size() == 0) begin
          failures++; $display("FAIL ovf_unexpected: idx=%0d data=%h with empty scoreboard", out_index, out_data);
        end else begin
          d = exp_data.pop_front(); i = exp_idx.pop_front();
          if (out_data !== d || out_index !== AW'(i) || out_eof !== (i == N-1)) begin
            failures++;
            $display("FAIL ovf_sample: data=%h idx=%0d eof=%b required data=%h idx=%0d", out_data, out_index, out_eof, d, i);
          end
        end
        got++;
      end
      @(posedge clk); #1; cyc++;
    end
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (got != 2*N || out_valid !== 1'b0 || overflow !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ovf_drain: got %0d valid=%b ovf=%b busy=%b required %0d 0 1 0", got, out_valid, overflow, busy, 2*N);
    end
  endtask

  task automatic test_reset_mid();
    int got = 0, cyc = 0, stray_valid = 0;
    logic [NB-1:0] d; int i;
    bit hit = 0;
    out_ready = 1'b1;
    fork
      send_frame(9, BEATS, 1'b1);
      begin
        while (!hit && cyc < 400) begin
          if (out_valid && out_index == AW'(30)) begin
            hit = 1;
          end else begin
            if (out_valid) begin
              checks++;
              d = exp_data.pop_front(); i = exp_idx.pop_front();
              if (out_data !== d || out_index !== AW'(i)) begin
                failures++;
                $display("FAIL rstmid_sample: data=%h idx=%0d required data=%h idx=%0d", out_data, out_index, d, i);
              end
            end
            @(posedge clk); #1; cyc++;
          end
        end
      end
    join
    checks++;
    if (!hit) begin failures++; $display("FAIL rstmid_reach: index 30 not seen within %0d cycles", cyc); end
    // Overflow is still sticky from the previous scenario; reset must clear it.
    reset = 1'b1;
    #1;
    checks++;
    if (out_data !== '0 || out_valid !== 1'b0 || out_sof !== 1'b0 || out_eof !== 1'b0 ||
        out_index !== '0 || overflow !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async: data=%h valid=%b sof=%b eof=%b idx=%0d ovf=%b busy=%b required all zero",
               out_data, out_valid, out_sof, out_eof, out_index, overflow, busy);
    end
    exp_data.delete();
    exp_idx.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      input_data = {$urandom, $urandom};
      if (out_valid !== 1'b0 || busy !== 1'b0) stray_valid++;
      @(posedge clk); #1;
    end
    checks++;
    if (stray_valid != 0) begin failures++; $display("FAIL rstmid_stray: %0d cycles with valid/busy high required 0", stray_valid); end
    cyc = 0;
    fork
      send_frame(10, BEATS, 1'b1);
      begin
        while (got < N && cyc < 400) begin
          if (out_valid) begin
            checks++;
            if (exp_data.size() == 0) begin
              failures++; $display("FAIL rstmid_unexpected: idx=%0d data=%h with empty scoreboard", out_index, out_data);
            end else begin
              d = exp_data.pop_front(); i = exp_idx.pop_front();
              if (out_data !== d || out_index !== AW'(i) || out_sof !== (i == 0) || out_eof !== (i == N-1)) begin
                failures++;
                $display("FAIL rstmid_new: data=%h idx=%0d sof=%b eof=%b required data=%h idx=%0d",
                         out_data, out_index, out_sof, out_eof, d, i);
              end
            end
            got++;
          end
          @(posedge clk); #1; cyc++;
        end
      end
    join
    checks++;
    if (got != N) begin failures++; $display("FAIL rstmid_timeout: got %0d samples required %0d", got, N); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random_ready();
    test_restart();
    test_overflow();
    test_reset_mid();
    checks++;
    if (exp_data.size() != 0) begin
      failures++; $display("FAIL scoreboard_leftover: %0d samples never delivered required 0", exp_data.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
